// File: rtl/axis_frame_driver_pkg.sv
// Shared definitions for axis_frame_driver: default geometry and FSM state encoding.
package axis_frame_driver_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefTxDataNum = 8;
  localparam int unsigned DefRxDataNum = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StRecv,
    StDone
  } state_e;

endpackage

// File: rtl/frame_counter.sv
// Beat counter for one frame direction.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous clear (start of transaction)
//   enable   : count one transferred beat
//   value    : current beat index
//   fin      : value is on the final beat of the frame
// The counter saturates on the final beat so it never wraps inside a frame.
module frame_counter #(
  parameter int unsigned COUNT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  output logic [$clog2(COUNT)-1:0]   value,
  output logic                       fin
);

  localparam int unsigned Width = $clog2(COUNT);

  logic [Width-1:0] valueQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valueQ <= '0;
    end else if (clear) begin
      valueQ <= '0;
    end else if (enable && !fin) begin
      valueQ <= valueQ + 1'b1;
    end
  end

  assign value = valueQ;
  assign fin   = (valueQ == Width'(COUNT - 1));

endmodule

// File: rtl/axis_frame_driver.sv
// Sends one TX_DATA_NUM-word frame read from a source memory on an AXIS master port,
// then receives one RX_DATA_NUM-word frame on an AXIS slave port into a result memory.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, busy, done        : transaction control / status (done is a 1-cycle pulse)
//   last_err                 : sticky inbound s_last framing error, cleared on start
//   tx_mem_adr, tx_mem_data  : source memory (combinational read)
//   m_data/valid/last/ready  : AXIS master (outbound frame)
//   s_data/valid/last/ready  : AXIS slave (inbound frame)
//   rx_mem_adr/data/wr       : result memory write port
module axis_frame_driver
  import axis_frame_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned TX_DATA_NUM = DefTxDataNum,
  parameter int unsigned RX_DATA_NUM = DefRxDataNum
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           last_err,
  output logic [$clog2(TX_DATA_NUM)-1:0] tx_mem_adr,
  input  logic [DATA_WIDTH-1:0]          tx_mem_data,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_valid,
  output logic                           m_last,
  input  logic                           m_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [$clog2(RX_DATA_NUM)-1:0] rx_mem_adr,
  output logic [DATA_WIDTH-1:0]          rx_mem_data,
  output logic                           rx_mem_wr
);

  state_e stateQ, stateD;
  logic   lastErrQ;
  logic   startAccept, txBeat, rxBeat, txFin, rxFin;

  logic [$clog2(TX_DATA_NUM)-1:0] txCount;
  logic [$clog2(RX_DATA_NUM)-1:0] rxCount;

  assign startAccept = (stateQ == StIdle) && start;
  assign txBeat      = (stateQ == StSend) && m_ready;
  assign rxBeat      = (stateQ == StRecv) && s_valid;

  frame_counter #(
    .COUNT (TX_DATA_NUM)
  ) u_tx_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (startAccept),
    .enable (txBeat),
    .value  (txCount),
    .fin    (txFin)
  );

  frame_counter #(
    .COUNT (RX_DATA_NUM)
  ) u_rx_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (startAccept),
    .enable (rxBeat),
    .value  (rxCount),
    .fin    (rxFin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (start) stateD = StSend;
      StSend:  if (txBeat && txFin) stateD = StRecv;
      StRecv:  if (rxBeat && rxFin) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Frame length is set by the count; s_last only flags a mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastErrQ <= 1'b0;
    end else if (startAccept) begin
      lastErrQ <= 1'b0;
    end else if (rxBeat && (s_last != rxFin)) begin
      lastErrQ <= 1'b1;
    end
  end

  // All outputs decode from registered state, so reset clears them immediately.
  always_comb begin
    busy        = (stateQ != StIdle);
    done        = (stateQ == StDone);
    last_err    = lastErrQ;
    tx_mem_adr  = txCount;
    m_data      = tx_mem_data;
    m_valid     = (stateQ == StSend);
    m_last      = (stateQ == StSend) && txFin;
    s_ready     = (stateQ == StRecv);
    rx_mem_wr   = rxBeat;
    rx_mem_adr  = rxCount;
    rx_mem_data = s_data;
  end

endmodule

// File: tb/tb_axis_frame_driver.sv
// Self-checking bench for axis_frame_driver with scoreboard queues for both streams.
module tb_axis_frame_driver;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, last_err;
  logic [2:0]    tx_mem_adr;
  logic [DW-1:0] tx_mem_data;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_ready;
  logic [1:0]    rx_mem_adr;
  logic [DW-1:0] rx_mem_data;
  logic          rx_mem_wr;

  int checks = 0;
  int errors = 0;
  int txBeats = 0;
  int doneCnt = 0;

  logic [DW-1:0] txMem [8];
  logic [DW:0]   txQ [$];   // {last, data}
  logic [DW+1:0] rxQ [$];   // {adr, data}

  logic          stallPrev = 1'b0;
  logic [DW-1:0] heldData;
  logic          heldLast;

  always #5 clk = ~clk;

  assign tx_mem_data = txMem[tx_mem_adr];

  axis_frame_driver dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .last_err    (last_err),
    .tx_mem_adr  (tx_mem_adr),
    .tx_mem_data (tx_mem_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .rx_mem_adr  (rx_mem_adr),
    .rx_mem_data (rx_mem_data),
    .rx_mem_wr   (rx_mem_wr)
  );

  // Stream monitor: pops the scoreboards on every handshake/write.
  always @(negedge clk) begin
    logic [DW:0]   expTx;
    logic [DW+1:0] expRx;
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== heldData || m_last !== heldLast) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, heldData, heldLast);
        end
      end
      if (m_valid && m_ready) begin
        txBeats++;
        checks++;
        if (txQ.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: unexpected beat d=%h l=%b", m_data, m_last);
        end else begin
          expTx = txQ.pop_front();
          if ({m_last, m_data} !== expTx) begin
            errors++;
            $display("FAIL tx_beat: got l=%b d=%h, want l=%b d=%h",
                     m_last, m_data, expTx[DW], expTx[DW-1:0]);
          end
        end
      end
      stallPrev = m_valid && !m_ready;
      heldData  = m_data;
      heldLast  = m_last;
      if (rx_mem_wr) begin
        checks++;
        if (rxQ.size() == 0) begin
          errors++;
          $display("FAIL rx_extra: unexpected write adr=%0d d=%h", rx_mem_adr, rx_mem_data);
        end else begin
          expRx = rxQ.pop_front();
          if ({rx_mem_adr, rx_mem_data} !== expRx) begin
            errors++;
            $display("FAIL rx_write: got adr=%0d d=%h, want adr=%0d d=%h",
                     rx_mem_adr, rx_mem_data, expRx[DW+1:DW], expRx[DW-1:0]);
          end
        end
      end
      if (done) doneCnt++;
    end
  end

  task automatic pushTx();
    for (int i = 0; i < 8; i++) txQ.push_back({(i == 7), txMem[i]});
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs the SEND phase; returns the number of m_valid cycles. Ends at a negedge in RECV.
  task automatic runTx(input bit toggle, input bit poke, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        break;
      end
      if (m_valid) cyc++;
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      start = poke;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout: RECV not reached, want RECV within 200 cycles");
    end
  endtask

  // Drives RX_DATA_NUM inbound beats back to back; returns one cycle into DONE.
  task automatic runRx(input int lastPos, input bit poke);
    for (int i = 0; i < 4; i++) rxQ.push_back({2'(i), DW'(32'hA0 + i)});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = DW'(32'hA0 + i);
      s_last  = (i == lastPos);
      start   = poke && (i != 3);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, last_err, m_valid, m_last, s_ready, rx_mem_wr} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000000",
               {busy, done, last_err, m_valid, m_last, s_ready, rx_mem_wr});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    int dc = doneCnt;
    m_ready = 1'b1;
    pushTx();
    pulseStart();
    runTx(1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL basic_send_len: got %0d want 8", cyc); end
    runRx(3, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (doneCnt != dc + 1) begin
      errors++; $display("FAIL basic_done_count: got %0d want %0d", doneCnt - dc, 1);
    end
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL basic_last_err: got %b want 0", last_err); end
    checks++;
    if (txQ.size() != 0 || rxQ.size() != 0) begin
      errors++; $display("FAIL basic_drain: got tx=%0d rx=%0d left want 0 0", txQ.size(), rxQ.size());
    end
  endtask

  task automatic test_stall();
    int cyc;
    int dc = doneCnt;
    m_ready = 1'b1;
    pushTx();
    pulseStart();
    runTx(1'b1, 1'b0, cyc);
    m_ready = 1'b1;
    checks++;
    if (cyc != 15) begin errors++; $display("FAIL stall_send_len: got %0d want 15", cyc); end
    runRx(3, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (doneCnt != dc + 1 || txQ.size() != 0 || rxQ.size() != 0) begin
      errors++;
      $display("FAIL stall_complete: got done=%0d tx=%0d rx=%0d want 1 0 0",
               doneCnt - dc, txQ.size(), rxQ.size());
    end
  endtask

  task automatic test_last_err();
    int cyc;
    m_ready = 1'b1;
    pushTx();
    pulseStart();
    runTx(1'b0, 1'b0, cyc);
    runRx(1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (last_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", last_err); end
    checks++;
    if (rxQ.size() != 0) begin errors++; $display("FAIL err_all_written: got %0d left want 0", rxQ.size()); end
    pushTx();
    pulseStart();
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", last_err); end
    runTx(1'b0, 1'b0, cyc);
    runRx(3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (last_err !== 1'b0) begin errors++; $display("FAIL err_clean_frame: got %b want 0", last_err); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int base = txBeats;
    int dc = doneCnt;
    bit got = 1'b0;
    m_ready = 1'b1;
    pushTx();
    pulseStart();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (txBeats >= base + 3) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++; $display("FAIL reset_mid_timeout: got %0d beats want 3", txBeats - base);
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_immediate: got v=%b busy=%b want 0 0", m_valid, busy);
    end
    txQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (doneCnt != dc || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_done: got done=%0d busy=%b want 0 0", doneCnt - dc, busy);
    end
    pushTx();
    pulseStart();
    checks++;
    if (tx_mem_adr !== 3'd0 || m_data !== 32'h10) begin
      errors++; $display("FAIL reset_mid_restart: got adr=%0d d=%h want 0 10", tx_mem_adr, m_data);
    end
    runTx(1'b0, 1'b0, cyc);
    runRx(3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (doneCnt != dc + 1 || txQ.size() != 0) begin
      errors++; $display("FAIL reset_mid_refrm: got done=%0d tx=%0d want 1 0", doneCnt - dc, txQ.size());
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int dc = doneCnt;
    m_ready = 1'b1;
    pushTx();
    pulseStart();
    runTx(1'b0, 1'b1, cyc);
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL poke_send_len: got %0d want 8", cyc); end
    runRx(3, 1'b1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || doneCnt != dc + 1 || txQ.size() != 0 || rxQ.size() != 0) begin
      errors++;
      $display("FAIL poke_frame: got busy=%b done=%0d tx=%0d rx=%0d want 0 1 0 0",
               busy, doneCnt - dc, txQ.size(), rxQ.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) txMem[i] = DW'(32'h10 + i);
    start   = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    test_reset();
    test_basic();
    test_stall();
    test_last_err();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_driver.md
AXIS_FRAME_DRIVER -- requirements
Module: axis_frame_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream and memory word width.
REQ-002 SHALL have parameter TX_DATA_NUM, default 8: words per outbound frame.
REQ-003 SHALL have parameter RX_DATA_NUM, default 4: words per inbound frame.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin one send/receive transaction.
REQ-008 SHALL have port busy, output, 1 bit: high whenever not in IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port last_err, output, 1 bit: sticky inbound framing error.
REQ-011 SHALL have port tx_mem_adr, output, clog2(TX_DATA_NUM) bits: source memory read address.
REQ-012 SHALL have port tx_mem_data, input, DATA_WIDTH bits: source memory word, combinational read.
REQ-013 SHALL have port m_data, output, DATA_WIDTH bits: AXIS master data.
REQ-014 SHALL have port m_valid, output, 1 bit: AXIS master valid.
REQ-015 SHALL have port m_last, output, 1 bit: AXIS master last.
REQ-016 SHALL have port m_ready, input, 1 bit: AXIS master ready.
REQ-017 SHALL have port s_data, input, DATA_WIDTH bits: AXIS slave data.
REQ-018 SHALL have port s_valid, input, 1 bit: AXIS slave valid.
REQ-019 SHALL have port s_last, input, 1 bit: AXIS slave last.
REQ-020 SHALL have port s_ready, output, 1 bit: AXIS slave ready.
REQ-021 SHALL have port rx_mem_adr, output, clog2(RX_DATA_NUM) bits: result memory write address.
REQ-022 SHALL have port rx_mem_data, output, DATA_WIDTH bits: result memory write data.
REQ-023 SHALL have port rx_mem_wr, output, 1 bit: result memory write enable.

Function
REQ-024 SHALL implement states IDLE, SEND, RECV, DONE.
REQ-025 SHALL make these transitions: IDLE->SEND on start; SEND->RECV on the final-beat handshake; RECV->DONE on the final-beat handshake; DONE->IDLE unconditionally.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL, on IDLE->SEND, clear both counters and last_err.
REQ-028 SHALL, in SEND, hold m_valid=1, with tx_mem_adr=tx count and m_data=tx_mem_data (zero added latency).
REQ-029 SHALL treat a beat as transferred only when m_valid&m_ready; tx count increments on each transferred beat.
REQ-030 SHALL hold m_data, m_valid and m_last stable while m_ready=0.
REQ-031 SHALL drive m_last=1 exactly while tx count==TX_DATA_NUM-1 in SEND.
REQ-032 SHALL, in RECV, drive s_ready=1, and on each s_valid write: rx_mem_wr=1, rx_mem_adr=rx count, rx_mem_data=s_data; rx count then increments.
REQ-033 SHALL delimit the inbound frame by count alone (RX_DATA_NUM beats); s_last does not terminate it early.
REQ-034 SHALL set last_err, held until the next accepted start, if s_last=1 on a beat other than the final one, or s_last=0 on the final beat.
REQ-035 SHALL drive done=1 for exactly the single DONE cycle.
REQ-036 SHALL allow a new start in the cycle after DONE.
REQ-037 SHALL drive m_valid=0 outside SEND and s_ready=0 outside RECV.
REQ-038 SHALL not wrap either counter within a frame; each counter is cleared only at start.

Reset
REQ-039 SHALL, while rst=1, immediately force IDLE, clear both counters, and set busy, done, last_err, m_valid, m_last, s_ready and rx_mem_wr to 0.
REQ-040 SHALL, on reset mid-frame, abandon the frame with no further handshakes, writes or done pulse.

Structure
REQ-041 SHALL place the state encoding and the DATA_WIDTH/TX_DATA_NUM/RX_DATA_NUM defaults in a shared package.
REQ-042 SHALL implement the tx and rx counters as one sub-module, frame_counter (clear, enable, value, fin), instantiated twice.

Verification
REQ-043 SHALL verify: tx memory words 0x10..0x17 with m_ready always 1 -> 8 beats on consecutive cycles, m_last only on 0x17, SEND lasts 8 cycles.
REQ-044 SHALL verify: m_ready toggling 1,0,1,0 -> each word held stable through stalls, with no drops or duplicates.
REQ-045 SHALL verify: 4 inbound words 0xA0..0xA3, s_last on 0xA3 -> rx_mem addresses 0..3 written in order, done pulses once, last_err=0.
REQ-046 SHALL verify: s_last on the 2nd of 4 inbound beats -> all 4 words still written, last_err=1, cleared by the next start.
REQ-047 SHALL verify: rst asserted after 3 beats sent -> m_valid and busy go 0 immediately, no done pulse; a following start resends from address 0.
REQ-048 SHALL verify: start pulsed during SEND or RECV -> no effect on the counts or the frame.
